icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache: the responder on the fetch interface (imemREN/imemaddr in, ihit/imemload out).
- Its ihit strobe is the one that advances the fetch/decode pipeline register and the PC.
- On a miss it issues a single-word fill request to the memory controller (iREN/iaddr out, iwait/iload in) and installs the returned word.
- One instance per core.

Parameters:
- SETS, 16, number of frames; power of two, >= 2.
- IDX_W, $clog2(SETS), index width, derived.
- TAG_W, 30 - IDX_W, tag width, derived.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous, active-low reset
- imemREN  input  1  fetch request from datapath
- imemaddr  input  32  fetch byte address; word-aligned, bits [1:0] ignored
- ihit  output  1  fetch data valid this cycle
- imemload  output  32  instruction word; valid when ihit=1
- iREN  output  1  fill request to memory controller
- iaddr  output  32  fill word address
- iwait  input  1  memory controller busy; 0 = iload valid this cycle
- iload  input  32  fill data from memory controller

Behaviour:
- Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2], byte offset = [1:0] (ignored).
- Storage: SETS frames, each holding {valid, tag[TAG_W], data[32]}.
- FSM states: IDLE, MISS.
- Reset (asynchronous, nRST low):
  - all valid bits = 0; tag and data fields = 0
  - state = IDLE; miss_addr register = 0
  - outputs: ihit = 0, imemload = 0, iREN = 0, iaddr = 0
- IDLE:
  - Lookup is combinational: hit = imemREN & frame[idx].valid & (frame[idx].tag == tag).
  - ihit = hit; imemload = hit ? frame[idx].data : 0; iREN = 0; iaddr = 0.
  - On imemREN & !hit: latch miss_addr = {imemaddr[31:2], 2'b00} and go to MISS at the next edge.
  - imemREN = 0: stay in IDLE, ihit = 0, no state change.
- MISS:
  - ihit = 0, imemload = 0, iREN = 1, iaddr = miss_addr.
  - iwait = 1: stay in MISS.
  - iwait = 0: at the edge, write frame[miss_addr idx] = {1, miss tag, iload}, then go to IDLE.
  - A fill unconditionally replaces the frame, evicting any valid frame at that index (no dirty state).
- Latency:
  - Hit: same cycle as the request (0 wait cycles).
  - Miss, iwait already 0 in the first MISS cycle: lookup cycle N misses, cycle N+1 is the fill, cycle N+2 hits. Minimum is 2 wait cycles.
  - Each extra iwait=1 cycle adds one cycle.
- Fill completion takes no hit in its own cycle; the next IDLE cycle re-looks-up the current imemaddr.
- Changes to imemaddr or imemREN during MISS have no effect on the fill:
  - The fill always uses miss_addr and always completes.
  - If the datapath has moved on (flush/branch), the next IDLE lookup uses the new address; the fetched line stays installed.
- Reset asserted during MISS:
  - iREN drops immediately (asynchronous); state = IDLE, all frames invalid.
  - Any iload arriving later is ignored.
- No invalidate/flush port; the cache is read-only and coherence with self-modifying code is not supported.
- No X on any output after reset; imemload is 0 whenever ihit = 0.

Decomposition:
- cpu_types_pkg additions:
  - word_t (32-bit)
  - icachef_t packed address struct {tag, idx, bytoff}, sized for the default SETS
  - icache_frame_t struct {valid, tag, data}
  - icache_state_t enum {IDLE, MISS}
- Single module. The frame array is a flop array inside icache; no sub-module is warranted at this size.

Test Plan:
- Reset then imemREN=1, imemaddr=0x0000_0000 -> ihit=0 in the lookup cycle; next cycle iREN=1, iaddr=0x0.
- Cold miss, memory returns iload=0x2001_0005 with iwait=1 for 3 MISS cycles then 0 -> fill on the 4th MISS cycle; ihit=1, imemload=0x2001_0005 the following cycle; iREN back to 0.
- Repeat fetch of 0x0, then 0x4 and 0x0 again -> 0x0 hits in 0 cycles; 0x4 misses (idx 1) and fills; the subsequent 0x0 still hits.
- Conflict: SETS=16, fill 0x0000_0000 then 0x0000_0040 (both idx 0) -> second fill evicts the first; re-fetch of 0x0 misses with iREN=1, iaddr=0x0.
- imemaddr changes 0x8 -> 0x100 while in MISS for 0x8 -> iaddr stays 0x8 until iwait=0; next cycle lookup of 0x100 misses and a new fill starts; a later fetch of 0x8 hits.
- nRST pulsed low mid-MISS -> iREN=0 and ihit=0 immediately; after release, a fetch of a previously filled address misses.
- imemREN=0 with a valid matching address -> ihit=0, imemload=0, iREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache address split, frame layout and FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-word fill on a miss.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t     r_state;
    logic [29:0]       r_miss_word;
    logic              r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS];
    word_t             r_data  [SETS];

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic [IDX_W-1:0]  w_fill_idx;
    logic              w_hit;
    logic              w_fill;
    logic              w_unused_bytoff;

    assign w_tag           = imemaddr[31:IDX_W+2];
    assign w_idx           = imemaddr[IDX_W+1:2];
    assign w_unused_bytoff = ^imemaddr[1:0];

    // The miss address is held as a word address; the fill target comes only from it,
    // so the datapath may change imemaddr freely while the fill is outstanding.
    assign w_fill_tag = r_miss_word[29:IDX_W];
    assign w_fill_idx = r_miss_word[IDX_W-1:0];

    assign w_hit  = (r_state == IDLE) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill = (r_state == MISS) && !iwait;

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'h0;
    assign iREN     = (r_state == MISS);
    assign iaddr    = iREN ? {r_miss_word, 2'b00} : 32'h0;

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_word <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_hit) begin
                        r_miss_word <= imemaddr[31:2];
                        r_state     <= MISS;
                    end
                end
                MISS: begin
                    if (!iwait) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A fill always overwrites its frame; there is no dirty state to preserve.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_tag[w_fill_idx]   <= w_fill_tag;
            r_data[w_fill_idx]  <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: drivers push expected fill requests and hit words, a monitor pops them.
module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    // Expected events: bit 32 = 1 for a hit (low bits = instruction), 0 for a fill request (low bits = iaddr).
    logic [32:0] exp_q[$];
    int          checks;
    int          errors;
    logic [32:0] mon_e;
    logic [31:0] cur_fill;
    logic        prev_iren;

    icache #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (ihit) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: got %h expected no hit at %0t", imemload, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hit_event", {1'b1, imemload}, mon_e);
            end
        end else begin
            chk("load_zero", {1'b0, imemload}, 33'h0);
        end
        if (iREN && !prev_iren) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                cur_fill = 32'h0;
                $display("FAIL unexpected_fill: got %h expected no request at %0t", iaddr, $time);
            end else begin
                mon_e = exp_q.pop_front();
                cur_fill = mon_e[31:0];
                chk("fill_req", {1'b0, iaddr}, mon_e);
            end
        end
        if (iREN) chk("fill_addr_hold", {1'b0, iaddr}, {1'b0, cur_fill});
        else      chk("iaddr_idle", {1'b0, iaddr}, 33'h0);
        prev_iren = iREN;
    end

    // Called one step after a rising edge with the cache in MISS; returns one step after the fill edge.
    task automatic miss_tail(input logic [31:0] data, input int waits);
        repeat (waits) begin
            iwait = 1'b1;
            iload = $urandom_range(32'hFFFF_FFFF, 0);
            @(posedge CLK); #1;
        end
        iwait = 1'b0;
        iload = data;
        @(posedge CLK); #1;
        iwait = 1'b1;
        iload = $urandom_range(32'hFFFF_FFFF, 0);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input bit hit, input int waits);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        if (hit) begin
            exp_q.push_back({1'b1, data});
            @(posedge CLK); #1;
            return;
        end
        exp_q.push_back({1'b0, addr[31:2], 2'b00});
        exp_q.push_back({1'b1, data});
        @(posedge CLK); #1;
        miss_tail(data, waits);
        chk("miss_latency", {32'h0, ihit}, 33'h1);
        @(posedge CLK); #1;
    endtask

    task automatic fetch_redirect(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] new_addr, input int waits);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        exp_q.push_back({1'b0, addr[31:2], 2'b00});
        @(posedge CLK); #1;
        imemaddr = new_addr;
        miss_tail(data, waits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cur_fill  = 32'h0;
        prev_iren = 1'b0;
        nRST      = 1'b0;
        imemREN   = 1'b0;
        imemaddr  = 32'h0;
        iwait     = 1'b1;
        iload     = 32'h0;
        #1;
        chk("rst_ihit", {32'h0, ihit}, 33'h0);
        chk("rst_imemload", {1'b0, imemload}, 33'h0);
        chk("rst_iren", {32'h0, iREN}, 33'h0);
        chk("rst_iaddr", {1'b0, iaddr}, 33'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Cold miss with three busy cycles, then hits and a second frame.
        fetch(32'h0000_0000, 32'h2001_0005, 1'b0, 3);
        fetch(32'h0000_0000, 32'h2001_0005, 1'b1, 0);
        fetch(32'h0000_0004, 32'h8C42_0004, 1'b0, 0);
        fetch(32'h0000_0000, 32'h2001_0005, 1'b1, 0);

        // 0x40 shares index 0 with 0x0 and evicts it.
        fetch(32'h0000_0040, 32'hAC03_0040, 1'b0, 1);
        fetch(32'h0000_0000, 32'h2001_0005, 1'b0, 0);
        fetch(32'h0000_0004, 32'h8C42_0004, 1'b1, 0);

        // Redirect during a miss: fill of 0x8 completes, then 0x100 is looked up.
        fetch_redirect(32'h0000_0008, 32'h1111_0008, 32'h0000_0100, 2);
        fetch(32'h0000_0100, 32'h2222_0100, 1'b0, 0);
        fetch(32'h0000_0008, 32'h1111_0008, 1'b1, 0);

        // No request: a resident address must not hit.
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0008;
        #1;
        chk("noreq_ihit", {32'h0, ihit}, 33'h0);
        chk("noreq_imemload", {1'b0, imemload}, 33'h0);
        chk("noreq_iren", {32'h0, iREN}, 33'h0);
        @(posedge CLK); #1;

        // Reset asserted in the middle of a miss.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_001C;
        iwait    = 1'b1;
        exp_q.push_back({1'b0, 32'h0000_001C});
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("miss_iren_before_rst", {32'h0, iREN}, 33'h1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_mid_iren", {32'h0, iREN}, 33'h0);
        chk("rst_mid_ihit", {32'h0, ihit}, 33'h0);
        chk("rst_mid_iaddr", {1'b0, iaddr}, 33'h0);
        exp_q.delete();
        iwait = 1'b0;
        iload = 32'h3333_001C;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        iwait = 1'b1;
        nRST  = 1'b1;

        // Everything was invalidated; offsets in bits [1:0] are ignored; tags must match fully.
        fetch(32'h0000_0004, 32'h8C42_0004, 1'b0, 0);
        fetch(32'h0000_0006, 32'h8C42_0004, 1'b1, 0);
        fetch(32'h8000_0004, 32'h5555_AAAA, 1'b0, 1);
        fetch(32'h0000_0004, 32'h8C42_0004, 1'b0, 0);
        fetch(32'h0000_0100, 32'h2222_0100, 1'b0, 0);

        imemREN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("queue_drain", 33'(exp_q.size()), 33'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
